// File: rtl/squeeze_expand_ctrl_if.sv
// Handshake and bank-control bundle between the squeeze stage, the
// squeeze/expand controller and the expand stage.
interface squeeze_expand_ctrl_if #(
  parameter int AW = 14,
  parameter int PW = 8
);
  logic          start;
  logic [AW-1:0] frame_len;
  logic [PW-1:0] passes;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic          wren;
  logic [AW-1:0] wr_addr;
  logic          rden;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, frame_len, passes, abort, in_valid, out_ready,
    input  in_ready, out_valid, wren, wr_addr, rden, rd_addr, busy, done, err
  );

  modport slave (
    input  start, frame_len, passes, abort, in_valid, out_ready,
    output in_ready, out_valid, wren, wr_addr, rden, rd_addr, busy, done, err
  );
endinterface

// File: rtl/squeeze_expand_ctrl.sv
// Squeeze/expand bank controller: fills one bank with frame_len words from
// the squeeze stage, then sweeps it `passes` times towards the expand stage.
module squeeze_expand_ctrl #(
  parameter int DEPTH = 12321,
  parameter int AW    = 14,
  parameter int PW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  squeeze_expand_ctrl_if.slave bus
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_cnt, rd_cnt, len_q;
  logic [PW-1:0] pass_cnt, passes_q;
  logic          err_q;

  logic start_ok;
  logic wr_acc, wr_last;
  logic rd_acc, rd_wrap, rd_final;

  // Handshake qualifiers and end-of-frame / end-of-sweep detection.
  always_comb begin
    start_ok = (bus.frame_len != '0) && (bus.frame_len <= DEPTH_W) && (bus.passes != '0);
    wr_acc   = (state == FILL) && bus.in_valid;
    wr_last  = (wr_cnt == len_q - ONE_A);
    rd_acc   = (state == DRAIN) && bus.out_ready;
    rd_wrap  = (rd_cnt == len_q - ONE_A);
    rd_final = rd_wrap && (pass_cnt == passes_q - ONE_P);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and state-decoded outputs; abort overrides every arc.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.wren      = 1'b0;
    bus.rden      = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start && start_ok) state_nxt = FILL;
      end
      FILL: begin
        bus.in_ready = 1'b1;
        bus.wren     = bus.in_valid;
        if (wr_acc && wr_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.rden      = 1'b1;
        bus.out_valid = 1'b1;
        if (rd_acc && rd_final) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  // Frame parameters, address counters and the rejected-start flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      pass_cnt <= '0;
      len_q    <= '0;
      passes_q <= '0;
      err_q    <= 1'b0;
    end else if (bus.abort) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      pass_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.start && !start_ok;
      case (state)
        IDLE: begin
          if (bus.start && start_ok) begin
            len_q    <= bus.frame_len;
            passes_q <= bus.passes;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            pass_cnt <= '0;
          end
        end
        FILL: begin
          if (wr_acc && !wr_last) wr_cnt <= wr_cnt + ONE_A;
        end
        DRAIN: begin
          if (rd_acc) begin
            if (rd_wrap) begin
              rd_cnt   <= '0;
              pass_cnt <= pass_cnt + ONE_P;
            end else begin
              rd_cnt <= rd_cnt + ONE_A;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_addr = wr_cnt;
  assign bus.rd_addr = rd_cnt;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_squeeze_expand_ctrl.sv
// Directed bench for squeeze_expand_ctrl: inputs change on the falling edge,
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_squeeze_expand_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  squeeze_expand_ctrl_if #(.AW(14), .PW(8)) bus ();

  squeeze_expand_ctrl #(.DEPTH(12321), .AW(14), .PW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.frame_len = '0; bus.passes = '0; bus.abort = 0;
    bus.in_valid = 0; bus.out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    bus.start = 1; bus.frame_len = 14'd4; bus.passes = 8'd1; bus.in_valid = 1; bus.abort = 1;
    step(); step(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.wren !== 1'b0 || bus.rden !== 1'b0) begin errors++; $display("FAIL reset_en got wren=%b rden=%b exp 0", bus.wren, bus.rden); end
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_hs got %b/%b exp 0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_pulse got done=%b err=%b exp 0", bus.done, bus.err); end
    checks++; if (bus.wr_addr !== 14'd0 || bus.rd_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0", bus.wr_addr, bus.rd_addr); end
    step(); rst = 0; idle_inputs(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [13:0] ew, er;
    step(); bus.start = 1; bus.frame_len = 14'd4; bus.passes = 8'd1; bus.in_valid = 1; bus.out_ready = 1;
    for (int c = 1; c <= 10; c++) begin
      step(); bus.start = 0; #1;
      ew = (c <= 4) ? 14'(c - 1) : 14'd3;
      er = (c >= 5 && c <= 8) ? 14'(c - 5) : 14'd0;
      checks++; if (bus.wren !== (c <= 4)) begin errors++; $display("FAIL basic_wren cyc %0d got %b exp %b", c, bus.wren, (c <= 4)); end
      checks++; if (bus.rden !== (c >= 5 && c <= 8)) begin errors++; $display("FAIL basic_rden cyc %0d got %b exp %b", c, bus.rden, (c >= 5 && c <= 8)); end
      checks++; if (bus.done !== (c == 9)) begin errors++; $display("FAIL basic_done cyc %0d got %b exp %b", c, bus.done, (c == 9)); end
      checks++; if (bus.busy !== (c <= 9)) begin errors++; $display("FAIL basic_busy cyc %0d got %b exp %b", c, bus.busy, (c <= 9)); end
      checks++; if (bus.wr_addr !== ew) begin errors++; $display("FAIL basic_wr_addr cyc %0d got %0d exp %0d", c, bus.wr_addr, ew); end
      checks++; if (bus.rd_addr !== er) begin errors++; $display("FAIL basic_rd_addr cyc %0d got %0d exp %0d", c, bus.rd_addr, er); end
    end
    idle_inputs();
  endtask

  task automatic test_multipass();
    logic [13:0] er;
    step(); bus.start = 1; bus.frame_len = 14'd3; bus.passes = 8'd2; bus.in_valid = 1;
    for (int c = 1; c <= 3; c++) begin
      step(); bus.start = 0; #1;
      checks++; if (bus.wren !== 1'b1 || bus.wr_addr !== 14'(c - 1)) begin errors++; $display("FAIL mp_fill cyc %0d got wren=%b addr=%0d exp 1/%0d", c, bus.wren, bus.wr_addr, c - 1); end
    end
    for (int k = 0; k < 12; k++) begin
      step(); bus.in_valid = 0; bus.out_ready = (k % 2 == 1); #1;
      er = 14'((k / 2) % 3);
      checks++; if (bus.out_valid !== 1'b1 || bus.rd_addr !== er) begin errors++; $display("FAIL mp_rd k %0d got valid=%b addr=%0d exp 1/%0d", k, bus.out_valid, bus.rd_addr, er); end
    end
    step(); bus.out_ready = 0; #1;
    checks++; if (bus.done !== 1'b1 || bus.rden !== 1'b0) begin errors++; $display("FAIL mp_done got done=%b rden=%b exp 1/0", bus.done, bus.rden); end
    step(); #1;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mp_after got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
    idle_inputs();
  endtask

  task automatic test_illegal();
    logic [13:0] lens [3];
    logic [7:0]  pss  [3];
    lens[0] = 14'd0;     pss[0] = 8'd1;
    lens[1] = 14'd12322; pss[1] = 8'd1;
    lens[2] = 14'd4;     pss[2] = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step(); bus.start = 1; bus.frame_len = lens[i]; bus.passes = pss[i]; bus.in_valid = 1;
      step(); bus.start = 0; #1;
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err case %0d got %b exp 1", i, bus.err); end
      checks++; if (bus.busy !== 1'b0 || bus.wren !== 1'b0) begin errors++; $display("FAIL ill_idle case %0d got busy=%b wren=%b exp 0/0", i, bus.busy, bus.wren); end
      step(); #1;
      checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ill_pulse case %0d got err=%b busy=%b exp 0/0", i, bus.err, bus.busy); end
    end
    // Largest legal frame is accepted; abort drops it again.
    step(); bus.start = 1; bus.frame_len = 14'd12321; bus.passes = 8'd1; bus.in_valid = 0;
    step(); bus.start = 0; #1;
    checks++; if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL depth_start got busy=%b err=%b rdy=%b exp 1/0/1", bus.busy, bus.err, bus.in_ready); end
    bus.abort = 1;
    step(); bus.abort = 0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL depth_abort got busy=%b exp 0", bus.busy); end
    idle_inputs();
  endtask

  task automatic test_gapped();
    logic pat [8];
    logic [13:0] n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    n = 14'd0;
    step(); bus.start = 1; bus.frame_len = 14'd5; bus.passes = 8'd1; bus.out_ready = 1;
    for (int c = 1; c <= 8; c++) begin
      step(); bus.start = 0; bus.in_valid = pat[c-1]; #1;
      checks++; if (bus.wren !== pat[c-1]) begin errors++; $display("FAIL gap_wren cyc %0d got %b exp %b", c, bus.wren, pat[c-1]); end
      if (pat[c-1]) begin
        checks++; if (bus.wr_addr !== n) begin errors++; $display("FAIL gap_addr cyc %0d got %0d exp %0d", c, bus.wr_addr, n); end
        n = n + 14'd1;
      end
    end
    step(); bus.in_valid = 1; #1;
    checks++; if (bus.rden !== 1'b1 || bus.wren !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL gap_drain got rden=%b wren=%b rdy=%b exp 1/0/0", bus.rden, bus.wren, bus.in_ready); end
    for (int c = 10; c <= 14; c++) begin
      step(); #1;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", bus.done); end
    idle_inputs();
  endtask

  task automatic test_abort();
    int dones;
    step(); bus.start = 1; bus.frame_len = 14'd4; bus.passes = 8'd1; bus.in_valid = 1; bus.out_ready = 1;
    for (int c = 1; c <= 6; c++) begin
      step(); bus.start = 0; #1;
    end
    step(); bus.abort = 1; #1;
    checks++; if (bus.rden !== 1'b1 || bus.rd_addr !== 14'd2) begin errors++; $display("FAIL ab_pre got rden=%b addr=%0d exp 1/2", bus.rden, bus.rd_addr); end
    dones = 0;
    step(); bus.abort = 0; #1;
    checks++; if (bus.busy !== 1'b0 || bus.rd_addr !== 14'd0 || bus.wr_addr !== 14'd0) begin errors++; $display("FAIL ab_idle got busy=%b rd=%0d wr=%0d exp 0/0/0", bus.busy, bus.rd_addr, bus.wr_addr); end
    for (int c = 0; c < 3; c++) begin
      if (bus.done) dones++;
      step(); #1;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL ab_nodone got %0d pulses exp 0", dones); end
    // abort and start together in IDLE: abort wins
    step(); bus.start = 1; bus.abort = 1;
    step(); bus.start = 0; bus.abort = 0; #1;
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL ab_start got busy=%b err=%b exp 0/0", bus.busy, bus.err); end
    // single-word frame, three passes
    step(); bus.start = 1; bus.frame_len = 14'd1; bus.passes = 8'd3;
    step(); bus.start = 0; #1;
    checks++; if (bus.wren !== 1'b1 || bus.wr_addr !== 14'd0) begin errors++; $display("FAIL one_wr got wren=%b addr=%0d exp 1/0", bus.wren, bus.wr_addr); end
    for (int c = 2; c <= 4; c++) begin
      step(); #1;
      checks++; if (bus.rden !== 1'b1 || bus.wren !== 1'b0 || bus.rd_addr !== 14'd0) begin errors++; $display("FAIL one_rd cyc %0d got rden=%b wren=%b addr=%0d exp 1/0/0", c, bus.rden, bus.wren, bus.rd_addr); end
    end
    step(); #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL one_done got %b exp 1", bus.done); end
    idle_inputs();
    // reset in the middle of FILL discards the frame
    step(); bus.start = 1; bus.frame_len = 14'd4; bus.passes = 8'd1; bus.in_valid = 1;
    step(); bus.start = 0;
    step(); rst = 1;
    step(); rst = 0; #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_addr !== 14'd0 || bus.wren !== 1'b0) begin errors++; $display("FAIL rst_mid got busy=%b done=%b wr=%0d wren=%b exp 0/0/0/0", bus.busy, bus.done, bus.wr_addr, bus.wren); end
    idle_inputs();
  endtask

  task automatic test_ignored_start();
    step(); bus.start = 1; bus.frame_len = 14'd4; bus.passes = 8'd1;
    step(); bus.start = 0;
    step(); bus.start = 1; bus.frame_len = 14'd2; bus.passes = 8'd1;
    step(); bus.start = 0; bus.in_valid = 1; #1;
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ign_state got err=%b busy=%b rdy=%b exp 0/1/1", bus.err, bus.busy, bus.in_ready); end
    checks++; if (bus.wr_addr !== 14'd0) begin errors++; $display("FAIL ign_addr0 got %0d exp 0", bus.wr_addr); end
    for (int c = 4; c <= 6; c++) begin
      step(); #1;
      checks++; if (bus.wren !== 1'b1 || bus.wr_addr !== 14'(c - 3)) begin errors++; $display("FAIL ign_fill cyc %0d got wren=%b addr=%0d exp 1/%0d", c, bus.wren, bus.wr_addr, c - 3); end
    end
    step(); #1;
    checks++; if (bus.rden !== 1'b1 || bus.wren !== 1'b0) begin errors++; $display("FAIL ign_drain got rden=%b wren=%b exp 1/0", bus.rden, bus.wren); end
    bus.abort = 1;
    step(); idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_multipass();
    test_illegal();
    test_gapped();
    test_abort();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
